ps2_matrix_kbd_gen: RTL and testbench

- Parametrised successor to the fixed 8x8 PS/2-to-matrix keyboard.
- Consumes a decoded PS/2 byte stream and handles the E0/F0/E1 prefixes internally.
- Translates scancodes through a run-time loadable map RAM into a ROWS x COLS active-low key matrix, which the CPU reads via row-select address lines.
- Also provides a Ctrl+F12 reset pulse, a release-all on overflow or CLEAR, and a map-init sweep after reset.

---
 rtl/ps2_matrix_kbd_gen.sv | 200 ++++++++++++++++++++
 tb/tb_ps2_matrix_kbd_gen.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/ps2_matrix_kbd_gen.sv
// PS/2 scancode stream to active-low ROWS x COLS key matrix, with a run-time
// loadable scancode map, Ctrl+F12 reset pulse and release-all handling.
module ps2_matrix_kbd_gen #(
    parameter int ROW_AW    = 3,
    parameter int COL_AW    = 3,
    parameter int RST_PULSE = 4096
) (
    input  logic                         KB_CLK,
    input  logic                         RESET,
    input  logic                         RX_VALID,
    input  logic [7:0]                   RX_DATA,
    input  logic                         MAP_WE,
    input  logic [8:0]                   MAP_ADDR,
    input  logic [ROW_AW+COL_AW:0]       MAP_WDATA,
    input  logic                         CLEAR,
    input  logic [(2**ROW_AW)-1:0]       KEY_ADDR,
    output logic [(2**COL_AW)-1:0]       KEY_DATA,
    output logic                         KEY_PRESSED,
    output logic                         MAP_READY,
    output logic                         CTRL_DOWN,
    output logic                         RESET_KEY_N
);

    localparam int ROWS = 2**ROW_AW;
    localparam int COLS = 2**COL_AW;
    localparam int IW   = ROW_AW + COL_AW;
    localparam int MW   = IW + 1;
    localparam int NK   = ROWS * COLS;
    localparam int PW   = (RST_PULSE > 2) ? $clog2(RST_PULSE) : 1;

    typedef enum logic [2:0] {IDLE, EXT, BRK, EXTBRK, SKIP} state_t;

    state_t          state_reg, state_next;
    logic [2:0]      skip_reg, skip_next;
    logic [8:0]      init_cnt_reg;
    logic            map_ready_reg;
    logic            ev_valid_reg, ev_make_reg;
    logic [8:0]      ev_addr_reg;
    logic            upd_valid_reg, upd_make_reg;
    logic [MW-1:0]   rd_data_reg;
    logic [NK-1:0]   matrix_reg;
    logic [1:0]      ctrl_reg;
    logic            rst_key_n_reg;
    logic [PW-1:0]   pulse_cnt_reg;

    logic            ev_fire, ev_make, overflow, combo, release_all;
    logic [8:0]      ev_addr;
    logic            wr_en;
    logic [8:0]      wr_addr;
    logic [MW-1:0]   wr_data;

    logic [MW-1:0]   map_mem [0:511];

    // Prefix decoder: turns the raw byte stream into make/break events.
    always_comb begin
        state_next = state_reg;
        skip_next  = skip_reg;
        ev_fire    = 1'b0;
        ev_make    = 1'b1;
        ev_addr    = {1'b0, RX_DATA};
        overflow   = 1'b0;
        if (RX_VALID && map_ready_reg) begin
            case (state_reg)
                IDLE: begin
                    case (RX_DATA)
                        8'hE0: state_next = EXT;
                        8'hF0: state_next = BRK;
                        8'hE1: begin
                            state_next = SKIP;
                            skip_next  = 3'd7;
                        end
                        8'h00, 8'hFF: overflow = 1'b1;
                        8'hAA, 8'hFA, 8'hEE, 8'hFE: ;
                        default: ev_fire = 1'b1;
                    endcase
                end
                EXT: begin
                    if (RX_DATA == 8'hF0) begin
                        state_next = EXTBRK;
                    end else begin
                        state_next = IDLE;
                        if (RX_DATA != 8'h12 && RX_DATA != 8'h59) begin
                            ev_fire = 1'b1;
                            ev_addr = {1'b1, RX_DATA};
                        end
                    end
                end
                BRK: begin
                    state_next = IDLE;
                    ev_fire    = 1'b1;
                    ev_make    = 1'b0;
                end
                EXTBRK: begin
                    state_next = IDLE;
                    if (RX_DATA != 8'h12 && RX_DATA != 8'h59) begin
                        ev_fire = 1'b1;
                        ev_make = 1'b0;
                        ev_addr = {1'b1, RX_DATA};
                    end
                end
                SKIP: begin
                    skip_next = skip_reg - 3'd1;
                    if (skip_reg <= 3'd1) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign combo       = ev_fire && ev_make && (ev_addr == 9'h007) && (|ctrl_reg) && rst_key_n_reg;
    assign release_all = CLEAR || overflow || combo;

    // Map RAM: the init sweep owns the write port until it completes.
    assign wr_en   = map_ready_reg ? MAP_WE : 1'b1;
    assign wr_addr = map_ready_reg ? MAP_ADDR : init_cnt_reg;
    assign wr_data = map_ready_reg ? MAP_WDATA : '0;

    always_ff @(posedge KB_CLK) begin
        if (wr_en) begin
            map_mem[wr_addr] <= wr_data;
        end
        rd_data_reg <= map_mem[ev_addr_reg];
    end

    always_ff @(posedge KB_CLK or posedge RESET) begin
        if (RESET) begin
            state_reg     <= IDLE;
            skip_reg      <= 3'd0;
            init_cnt_reg  <= 9'd0;
            map_ready_reg <= 1'b0;
            ev_valid_reg  <= 1'b0;
            ev_make_reg   <= 1'b0;
            ev_addr_reg   <= 9'd0;
            upd_valid_reg <= 1'b0;
            upd_make_reg  <= 1'b0;
            matrix_reg    <= '1;
            ctrl_reg      <= 2'b00;
            rst_key_n_reg <= 1'b1;
            pulse_cnt_reg <= '0;
        end else begin
            state_reg <= state_next;
            skip_reg  <= skip_next;

            if (!map_ready_reg) begin
                if (init_cnt_reg == 9'd511) begin
                    map_ready_reg <= 1'b1;
                end else begin
                    init_cnt_reg <= init_cnt_reg + 9'd1;
                end
            end

            ev_valid_reg  <= ev_fire;
            ev_make_reg   <= ev_make;
            ev_addr_reg   <= ev_addr;
            upd_valid_reg <= ev_valid_reg;
            upd_make_reg  <= ev_make_reg;

            if (ev_fire && ev_addr[7:0] == 8'h14) begin
                ctrl_reg[ev_addr[8]] <= ev_make;
            end

            if (combo) begin
                rst_key_n_reg <= 1'b0;
                pulse_cnt_reg <= PW'(RST_PULSE - 1);
            end else if (!rst_key_n_reg) begin
                if (pulse_cnt_reg == '0) begin
                    rst_key_n_reg <= 1'b1;
                end else begin
                    pulse_cnt_reg <= pulse_cnt_reg - 1'b1;
                end
            end

            // Release-all takes priority over a pipeline update landing this cycle.
            if (release_all) begin
                matrix_reg <= '1;
            end else if (upd_valid_reg && rd_data_reg[MW-1]) begin
                matrix_reg[rd_data_reg[IW-1:0]] <= ~upd_make_reg;
            end
        end
    end

    genvar gi, gr;
    generate
        for (gi = 0; gi < COLS; gi++) begin : g_col
            logic [ROWS-1:0] hit;
            for (gr = 0; gr < ROWS; gr++) begin : g_row
                assign hit[gr] = ~KEY_ADDR[gr] & ~matrix_reg[gr*COLS + gi];
            end
            assign KEY_DATA[gi] = ~|hit;
        end
    endgenerate

    assign KEY_PRESSED = ~&matrix_reg;
    assign MAP_READY   = map_ready_reg;
    assign CTRL_DOWN   = |ctrl_reg;
    assign RESET_KEY_N = rst_key_n_reg;

endmodule

// File: tb/tb_ps2_matrix_kbd_gen.sv
// Directed bench for ps2_matrix_kbd_gen: init sweep, mapping, prefixes,
// multi-row read, reset combo, release-all and Pause skipping.
module tb_ps2_matrix_kbd_gen;

    logic       KB_CLK = 1'b0;
    logic       RESET;
    logic       RX_VALID;
    logic [7:0] RX_DATA;
    logic       MAP_WE;
    logic [8:0] MAP_ADDR;
    logic [6:0] MAP_WDATA;
    logic       CLEAR;
    logic [7:0] KEY_ADDR;
    logic [7:0] KEY_DATA;
    logic       KEY_PRESSED;
    logic       MAP_READY;
    logic       CTRL_DOWN;
    logic       RESET_KEY_N;

    int checks   = 0;
    int failures = 0;

    ps2_matrix_kbd_gen #(.ROW_AW(3), .COL_AW(3), .RST_PULSE(16)) dut (
        .KB_CLK(KB_CLK), .RESET(RESET), .RX_VALID(RX_VALID), .RX_DATA(RX_DATA),
        .MAP_WE(MAP_WE), .MAP_ADDR(MAP_ADDR), .MAP_WDATA(MAP_WDATA), .CLEAR(CLEAR),
        .KEY_ADDR(KEY_ADDR), .KEY_DATA(KEY_DATA), .KEY_PRESSED(KEY_PRESSED),
        .MAP_READY(MAP_READY), .CTRL_DOWN(CTRL_DOWN), .RESET_KEY_N(RESET_KEY_N)
    );

    always #5 KB_CLK = ~KB_CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge KB_CLK);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        RX_DATA  = b;
        RX_VALID = 1'b1;
        tick();
        RX_VALID = 1'b0;
    endtask

    task automatic map_wr(input logic [8:0] a, input logic [6:0] d);
        MAP_ADDR  = a;
        MAP_WDATA = d;
        MAP_WE    = 1'b1;
        tick();
        MAP_WE    = 1'b0;
    endtask

    task automatic tick2();
        tick();
        tick();
    endtask

    initial begin
        RESET = 1'b1; RX_VALID = 1'b0; RX_DATA = 8'h00; MAP_WE = 1'b0;
        MAP_ADDR = 9'h0; MAP_WDATA = 7'h0; CLEAR = 1'b0; KEY_ADDR = 8'h00;
        tick(); tick(); tick();
        chk("rst_key_data", KEY_DATA, 8'hFF);
        chk("rst_pressed", KEY_PRESSED, 1'b0);
        chk("rst_map_ready", MAP_READY, 1'b0);
        chk("rst_ctrl", CTRL_DOWN, 1'b0);
        chk("rst_key_n", RESET_KEY_N, 1'b1);

        // Sweep: an RX byte and a map write during the sweep must be ignored.
        RESET = 1'b0;
        for (int i = 1; i <= 512; i++) begin
            if (i == 200) begin RX_DATA = 8'h1C; RX_VALID = 1'b1; end
            if (i == 300) begin MAP_ADDR = 9'h01C; MAP_WDATA = 7'b1_100_101; MAP_WE = 1'b1; end
            tick();
            RX_VALID = 1'b0;
            MAP_WE   = 1'b0;
            if (i == 511) chk("sweep_ready_511", MAP_READY, 1'b0);
            if (i == 512) chk("sweep_ready_512", MAP_READY, 1'b1);
        end
        chk("sweep_rx_ignored", KEY_PRESSED, 1'b0);
        send(8'h1C); tick2();
        chk("sweep_mapwe_ignored", KEY_DATA, 8'hFF);
        send(8'hF0); send(8'h1C); tick2();

        // Basic make/break with latency check.
        map_wr(9'h01C, 7'b1_100_101);
        KEY_ADDR = 8'hEF;
        send(8'h1C);
        tick();
        chk("make_latency1", KEY_DATA, 8'hFF);
        tick();
        chk("make_1c", KEY_DATA, 8'hDF);
        chk("make_pressed", KEY_PRESSED, 1'b1);
        send(8'hF0); send(8'h1C); tick2();
        chk("break_1c", KEY_DATA, 8'hFF);
        chk("break_pressed", KEY_PRESSED, 1'b0);

        // Extended codes.
        map_wr(9'h174, 7'b1_010_000);
        KEY_ADDR = 8'hFB;
        send(8'hE0); send(8'h74); tick2();
        chk("ext_make", KEY_DATA, 8'hFE);
        send(8'hE0); send(8'hF0); send(8'h74); tick2();
        chk("ext_break", KEY_DATA, 8'hFF);
        send(8'hE0); send(8'h74); tick2();
        send(8'hE0); send(8'h12); tick2();
        chk("fake_shift_make", KEY_DATA, 8'hFE);
        send(8'hE0); send(8'hF0); send(8'h12); tick2();
        chk("fake_shift_break", KEY_DATA, 8'hFE);
        send(8'hF0); send(8'h74); tick2();
        chk("unmapped_074", KEY_DATA, 8'hFE);
        send(8'hE0); send(8'hF0); send(8'h74); tick2();
        chk("ext_break2", KEY_PRESSED, 1'b0);

        // Multi-row read.
        map_wr(9'h015, 7'b1_000_011);
        map_wr(9'h01D, 7'b1_101_011);
        send(8'h15); send(8'h1D); tick2();
        KEY_ADDR = 8'hDE; #1;
        chk("multirow_de", KEY_DATA, 8'hF7);
        KEY_ADDR = 8'hFF; #1;
        chk("multirow_ff", KEY_DATA, 8'hFF);
        KEY_ADDR = 8'h7F; #1;
        chk("multirow_row7", KEY_DATA, 8'hFF);

        // Overflow byte releases all.
        send(8'h00);
        chk("overflow_release", KEY_PRESSED, 1'b0);

        // Ctrl+F12 reset combo.
        send(8'h15); tick2();
        chk("combo_pre_pressed", KEY_PRESSED, 1'b1);
        send(8'h14);
        chk("ctrl_left_down", CTRL_DOWN, 1'b1);
        send(8'h07);
        chk("combo_low", RESET_KEY_N, 1'b0);
        chk("combo_release", KEY_PRESSED, 1'b0);
        for (int k = 1; k <= 16; k++) begin
            if (k == 5) begin RX_DATA = 8'h07; RX_VALID = 1'b1; end
            tick();
            RX_VALID = 1'b0;
            chk($sformatf("combo_pulse_k%0d", k), RESET_KEY_N, (k < 16) ? 1'b0 : 1'b1);
        end
        send(8'h07);
        chk("combo_retrigger", RESET_KEY_N, 1'b0);
        for (int k = 0; k < 16; k++) tick();
        chk("combo_retrigger_end", RESET_KEY_N, 1'b1);
        send(8'hF0); send(8'h14);
        chk("ctrl_left_up", CTRL_DOWN, 1'b0);
        send(8'hE0); send(8'h14);
        chk("ctrl_right_down", CTRL_DOWN, 1'b1);
        send(8'hE0); send(8'hF0); send(8'h14);
        chk("ctrl_right_up", CTRL_DOWN, 1'b0);
        send(8'h07); tick();
        chk("no_combo_without_ctrl", RESET_KEY_N, 1'b1);

        // CLEAR coincident with a make landing in the matrix.
        send(8'h15);
        tick();
        CLEAR = 1'b1;
        tick();
        CLEAR = 1'b0;
        chk("clear_wins", KEY_PRESSED, 1'b0);
        tick2();
        chk("clear_stays", KEY_PRESSED, 1'b0);

        // Pause sequence is swallowed, then normal decoding resumes.
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
        tick2();
        chk("pause_no_event", KEY_PRESSED, 1'b0);
        chk("pause_no_ctrl", CTRL_DOWN, 1'b0);
        KEY_ADDR = 8'hEF;
        send(8'h1C); tick2();
        chk("pause_then_make", KEY_DATA, 8'hDF);

        // Asynchronous reset mid-operation wipes the map.
        #2 RESET = 1'b1;
        #1;
        chk("async_rst_data", KEY_DATA, 8'hFF);
        chk("async_rst_ready", MAP_READY, 1'b0);
        tick();
        RESET = 1'b0;
        for (int i = 0; i < 512; i++) tick();
        chk("resweep_ready", MAP_READY, 1'b1);
        send(8'h1C); tick2();
        chk("resweep_map_wiped", KEY_DATA, 8'hFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
